// File: rtl/snn_pkg.sv
// snn_pkg: shared constants and types for the SNN image loader.
//   IMG_PIXELS     pixels per image (28x28)
//   IMG_BYTES      bytes per image, 8 pixels packed per byte
//   IMG_ADDR_W     address width of the 1024x1 image RAM
//   img_addr_t     image RAM address type
//   loader_state_t loader FSM states
package snn_pkg;

    localparam int IMG_PIXELS = 784;
    localparam int IMG_BYTES  = IMG_PIXELS / 8;
    localparam int IMG_ADDR_W = 10;

    typedef logic [IMG_ADDR_W-1:0] img_addr_t;

    typedef enum logic [1:0] {
        IDLE,
        UNPACK,
        READY
    } loader_state_t;

endpackage

// File: rtl/snn_byte_unpacker.sv
// snn_byte_unpacker: 8-cycle serializer, LSB first.
//   clk, rst   system clock, synchronous active-high reset
//   load       capture load_data and start (or restart) serializing
//   load_data  byte to serialize
//   active     high for the 8 cycles a bit is presented (registered)
//   bit_out    current bit, shift[0] (registered)
//   done       active and presenting bit 7; a load in this cycle
//              chains the next byte with no gap
module snn_byte_unpacker (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_data,
    output logic       active,
    output logic       bit_out,
    output logic       done
);

    logic [7:0] shift;
    logic [2:0] bit_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift   <= 8'h00;
            bit_idx <= 3'd0;
            active  <= 1'b0;
        end else if (load) begin
            shift   <= load_data;
            bit_idx <= 3'd0;
            active  <= 1'b1;
        end else if (active) begin
            // Zero fill so bit_out idles low once the byte is consumed.
            shift   <= {1'b0, shift[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
                active <= 1'b0;
            end
        end
    end

    assign bit_out = shift[0];
    assign done    = active && (bit_idx == 3'd7);

endmodule

// File: rtl/snn_img_loader.sv
// snn_img_loader: unpacks received UART bytes into single-bit writes to the
// SNN core's input-image RAM, then signals img_rdy and waits for img_ack.
//   clk, rst   50 MHz clock, synchronous active-high reset
//   rx_rdy     one-cycle strobe, rx_data valid
//   rx_data    received byte
//   ram_we     image RAM write enable
//   ram_addr   image RAM write address (8*byte_cnt + bit index)
//   ram_wdata  pixel bit
//   img_rdy    full image stored, held until img_ack
//   img_ack    one-cycle strobe from the core, image consumed
//   byte_cnt   bytes accepted for the current image
//   overrun    sticky, a byte was dropped (or a timeout resync happened)
//   busy       high while unpacking
// Optional: define IMG_TIMEOUT_EN to resynchronise after an inter-byte gap
// of TIMEOUT_CYCLES clocks in a partially received image.
//
// Handshake: rx_rdy and img_ack are pure strobes with no ready/backpressure.
// A byte is taken when the holding register is empty or is being drained in
// the same cycle (and the loader is not in READY); otherwise it is lost and
// overrun is raised. img_ack is only honoured in READY.
module snn_img_loader
    import snn_pkg::*;
#(
    parameter int NUM_BYTES      = IMG_BYTES,
    parameter int ADDR_W         = IMG_ADDR_W,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wdata,
    output logic              img_rdy,
    input  logic              img_ack,
    output logic [6:0]        byte_cnt,
    output logic              overrun,
    output logic              busy
);

    loader_state_t state;
    logic          hold_vld;
    logic [7:0]    hold_data;
    logic          unpack_done;
    logic          last_byte;
    logic          load_idle;
    logic          load_next;
    logic          load;
    logic          capture;
    logic          drop;
    logic          ack;
    logic          timeout;

    assign last_byte = (byte_cnt == 7'(NUM_BYTES - 1));
    assign load_idle = (state == IDLE) && hold_vld;
    // Chain the held byte straight after bit 7 unless the image is complete.
    assign load_next = (state == UNPACK) && unpack_done && hold_vld && !last_byte;
    assign load      = load_idle || load_next;
    assign capture   = rx_rdy && (state != READY) && (!hold_vld || load);
    assign drop      = rx_rdy && !capture;
    assign ack       = (state == READY) && img_ack;

    snn_byte_unpacker u_unpacker (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (hold_data),
        .active    (ram_we),
        .bit_out   (ram_wdata),
        .done      (unpack_done)
    );

`ifdef IMG_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TO_W-1:0] to_cnt;
    logic            to_run;

    // Only a genuinely idle gap inside a partial image counts; any arriving
    // byte (captured in IDLE) restarts the gap.
    assign to_run  = (state == IDLE) && !hold_vld && !rx_rdy &&
                     (byte_cnt != 7'd0) && (byte_cnt < 7'(NUM_BYTES));
    assign timeout = to_run && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || !to_run || timeout) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + TO_W'(1);
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold_vld  <= 1'b0;
            hold_data <= 8'h00;
            byte_cnt  <= 7'd0;
            ram_addr  <= '0;
            img_rdy   <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            if (capture) begin
                hold_vld  <= 1'b1;
                hold_data <= rx_data;
            end else if (load) begin
                hold_vld <= 1'b0;
            end

            // Ack beats a coincident dropped byte.
            if (ack) begin
                overrun <= 1'b0;
            end else if (drop || timeout) begin
                overrun <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (timeout) begin
                        byte_cnt <= 7'd0;
                    end
                    if (hold_vld) begin
                        state    <= UNPACK;
                        busy     <= 1'b1;
                        ram_addr <= ADDR_W'({byte_cnt, 3'b000});
                    end
                end
                UNPACK: begin
                    if (!unpack_done || load_next) begin
                        ram_addr <= ram_addr + ADDR_W'(1);
                    end
                    if (unpack_done) begin
                        byte_cnt <= byte_cnt + 7'd1;
                        if (last_byte) begin
                            state   <= READY;
                            busy    <= 1'b0;
                            img_rdy <= 1'b1;
                        end else if (!hold_vld) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                READY: begin
                    if (img_ack) begin
                        state    <= IDLE;
                        img_rdy  <= 1'b0;
                        byte_cnt <= 7'd0;
                        ram_addr <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snn_img_loader.sv
// tb_snn_img_loader: directed self-checking bench for snn_img_loader.
// Build with +define+IMG_TIMEOUT_EN to exercise the timeout resync path
// (the DUT is then configured with TIMEOUT_CYCLES=100).
module tb_snn_img_loader;

`ifdef IMG_TIMEOUT_EN
    localparam int TB_TIMEOUT = 100;
`else
    localparam int TB_TIMEOUT = 500000;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_rdy = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       img_ack = 1'b0;
    logic       ram_we;
    logic [9:0] ram_addr;
    logic       ram_wdata;
    logic       img_rdy;
    logic [6:0] byte_cnt;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    snn_img_loader #(
        .NUM_BYTES      (98),
        .ADDR_W         (10),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_rdy    (rx_rdy),
        .rx_data   (rx_data),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .img_rdy   (img_rdy),
        .img_ack   (img_ack),
        .byte_cnt  (byte_cnt),
        .overrun   (overrun),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- write monitor / shadow RAM ----------------
    logic [10:0] wr_q[$];      // {addr, data}
    int          wr_cyc_q[$];
    logic [10:0] exp_q[$];
    logic        shadow [1024];
    int          hi_writes = 0;
    int          w783_cyc = -1;
    int          rdy_rise_cyc = -1;
    logic        rdy_prev = 1'b0;

    always @(posedge clk) begin
        #1;
        if (ram_we) begin
            wr_q.push_back({ram_addr, ram_wdata});
            wr_cyc_q.push_back(cyc);
            shadow[ram_addr] = ram_wdata;
            if (ram_addr > 10'd783) hi_writes++;
            if (ram_addr == 10'd783) w783_cyc = cyc;
        end
        if (img_rdy && !rdy_prev) rdy_rise_cyc = cyc;
        rdy_prev = img_rdy;
    end

    // ---------------- driver tasks (called and return at a negedge) ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, output int s);
        rx_data = b;
        rx_rdy  = 1'b1;
        s       = cyc;
        @(negedge clk);
        rx_rdy  = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(1);
    endtask

    task automatic clear_logs();
        wr_q.delete();
        wr_cyc_q.delete();
        exp_q.delete();
    endtask

    // Expected writes for one byte: LSB first at base..base+7.
    task automatic push_exp(input int base, input logic [7:0] b);
        for (int j = 0; j < 8; j++) exp_q.push_back({10'(base + j), b[j]});
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        n_checks++;
        if ({ram_we, ram_addr, ram_wdata, img_rdy, byte_cnt, overrun, busy} !== 22'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got we=%b addr=%0d wd=%b rdy=%b cnt=%0d ovr=%b busy=%b, expected all 0",
                     ram_we, ram_addr, ram_wdata, img_rdy, byte_cnt, overrun, busy);
        end
        rst = 1'b0;
        idle(1);
    endtask

    task automatic test_single_byte();
        int s;
        clear_logs();
        push_exp(0, 8'hA5);       // bits 1,0,1,0,0,1,0,1 at 0..7
        send_byte(8'hA5, s);
        idle(12);
        n_checks++;
        if (wr_q.size() != 8) begin
            n_errors++;
            $display("FAIL single_count: got %0d writes, expected 8", wr_q.size());
        end
        for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
            n_checks++;
            if (wr_q[i] !== exp_q[i] || wr_cyc_q[i] !== s + 2 + i) begin
                n_errors++;
                $display("FAIL single_write%0d: got addr=%0d d=%b cyc=%0d, expected addr=%0d d=%b cyc=%0d",
                         i, wr_q[i][10:1], wr_q[i][0], wr_cyc_q[i], exp_q[i][10:1], exp_q[i][0], s + 2 + i);
            end
        end
        n_checks++;
        if (byte_cnt !== 7'd1 || busy !== 1'b0 || overrun !== 1'b0 || img_rdy !== 1'b0) begin
            n_errors++;
            $display("FAIL single_status: got cnt=%0d busy=%b ovr=%b rdy=%b, expected 1 0 0 0",
                     byte_cnt, busy, overrun, img_rdy);
        end
        // img_ack outside READY must be ignored.
        img_ack = 1'b1;
        idle(1);
        img_ack = 1'b0;
        idle(2);
        n_checks++;
        if (byte_cnt !== 7'd1 || img_rdy !== 1'b0) begin
            n_errors++;
            $display("FAIL stray_ack: got cnt=%0d rdy=%b, expected 1 0", byte_cnt, img_rdy);
        end
    endtask

    task automatic test_full_image();
        logic [7:0] img [98];
        logic [7:0] got;
        int s;
        int k;
        apply_reset();
        clear_logs();
        for (int a = 0; a < 1024; a++) shadow[a] = 1'bx;
        hi_writes    = 0;
        w783_cyc     = -1;
        rdy_rise_cyc = -1;
        for (int i = 0; i < 98; i++) img[i] = 8'((i * 73 + 29) ^ (i << 2));
        for (int i = 0; i < 98; i++) begin
            send_byte(img[i], s);
            idle(9);
        end
        k = 0;
        while (!img_rdy && k < 40) begin
            idle(1);
            k++;
        end
        n_checks++;
        if (img_rdy !== 1'b1 || byte_cnt !== 7'd98 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL full_ready: got rdy=%b cnt=%0d busy=%b, expected 1 98 0", img_rdy, byte_cnt, busy);
        end
        n_checks++;
        if (wr_q.size() != 784) begin
            n_errors++;
            $display("FAIL full_count: got %0d writes, expected 784", wr_q.size());
        end
        for (int i = 0; i < 98; i++) begin
            for (int j = 0; j < 8; j++) got[j] = shadow[8 * i + j];
            n_checks++;
            if (got !== img[i]) begin
                n_errors++;
                $display("FAIL full_byte%0d: got %h, expected %h", i, got, img[i]);
            end
        end
        n_checks++;
        if (w783_cyc < 0 || rdy_rise_cyc !== w783_cyc + 1) begin
            n_errors++;
            $display("FAIL full_rdy_latency: got rise cyc %0d, expected %0d", rdy_rise_cyc, w783_cyc + 1);
        end
        n_checks++;
        if (hi_writes !== 0) begin
            n_errors++;
            $display("FAIL full_addr_range: got %0d writes above 783, expected 0", hi_writes);
        end
    endtask

    // Starts in READY, left there by test_full_image.
    task automatic test_ready_hold();
        int s;
        clear_logs();
        send_byte(8'hFF, s);
        idle(4);
        n_checks++;
        if (wr_q.size() != 0 || overrun !== 1'b1 || img_rdy !== 1'b1) begin
            n_errors++;
            $display("FAIL ready_drop: got writes=%0d ovr=%b rdy=%b, expected 0 1 1", wr_q.size(), overrun, img_rdy);
        end
        // Ack together with a byte: ack wins, byte dropped, overrun cleared.
        img_ack = 1'b1;
        rx_data = 8'h77;
        rx_rdy  = 1'b1;
        idle(1);
        img_ack = 1'b0;
        rx_rdy  = 1'b0;
        n_checks++;
        if (img_rdy !== 1'b0 || byte_cnt !== 7'd0 || overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL ready_ack: got rdy=%b cnt=%0d ovr=%b, expected 0 0 0", img_rdy, byte_cnt, overrun);
        end
        idle(4);
        n_checks++;
        if (wr_q.size() != 0 || overrun !== 1'b0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL ack_drop: got writes=%0d ovr=%b busy=%b, expected 0 0 0", wr_q.size(), overrun, busy);
        end
        push_exp(0, 8'h3C);
        send_byte(8'h3C, s);
        idle(12);
        n_checks++;
        if (wr_q.size() != 8) begin
            n_errors++;
            $display("FAIL after_ack_count: got %0d writes, expected 8", wr_q.size());
        end
        for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
            n_checks++;
            if (wr_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL after_ack_write%0d: got addr=%0d d=%b, expected addr=%0d d=%b",
                         i, wr_q[i][10:1], wr_q[i][0], exp_q[i][10:1], exp_q[i][0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int s;
        int s2;
        int s3;
        apply_reset();
        clear_logs();
        push_exp(0, 8'h96);
        push_exp(8, 8'h0F);
        send_byte(8'h96, s);
        send_byte(8'h0F, s2);
        idle(1);
        send_byte(8'hE1, s3);
        idle(20);
        n_checks++;
        if (wr_q.size() != 16) begin
            n_errors++;
            $display("FAIL b2b_count: got %0d writes, expected 16", wr_q.size());
        end
        for (int i = 0; i < 16 && i < wr_q.size(); i++) begin
            n_checks++;
            if (wr_q[i] !== exp_q[i] || wr_cyc_q[i] !== s + 2 + i) begin
                n_errors++;
                $display("FAIL b2b_write%0d: got addr=%0d d=%b cyc=%0d, expected addr=%0d d=%b cyc=%0d",
                         i, wr_q[i][10:1], wr_q[i][0], wr_cyc_q[i], exp_q[i][10:1], exp_q[i][0], s + 2 + i);
            end
        end
        n_checks++;
        if (overrun !== 1'b1 || byte_cnt !== 7'd2) begin
            n_errors++;
            $display("FAIL b2b_status: got ovr=%b cnt=%0d, expected 1 2", overrun, byte_cnt);
        end
    endtask

    task automatic test_reset_mid_unpack();
        int s;
        int k;
        bit found;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            send_byte(8'(8'h21 * i + 3), s);
            idle(9);
        end
        send_byte(8'hC3, s);
        found = 1'b0;
        k = 0;
        while (!found && k < 20) begin
            if (ram_we === 1'b1 && ram_addr === 10'd43) found = 1'b1;
            else begin
                idle(1);
                k++;
            end
        end
        n_checks++;
        if (!found) begin
            n_errors++;
            $display("FAIL rst_mid_find: got no write to address 43 within 20 cycles, expected one");
        end
        rst = 1'b1;
        idle(1);
        n_checks++;
        if ({ram_we, ram_addr, ram_wdata, img_rdy, byte_cnt, overrun, busy} !== 22'd0) begin
            n_errors++;
            $display("FAIL rst_mid_outputs: got we=%b addr=%0d wd=%b rdy=%b cnt=%0d ovr=%b busy=%b, expected all 0",
                     ram_we, ram_addr, ram_wdata, img_rdy, byte_cnt, overrun, busy);
        end
        rst = 1'b0;
        idle(2);
        clear_logs();
        push_exp(0, 8'h5A);
        send_byte(8'h5A, s);
        idle(12);
        n_checks++;
        if (wr_q.size() != 8) begin
            n_errors++;
            $display("FAIL rst_mid_count: got %0d writes, expected 8", wr_q.size());
        end
        for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
            n_checks++;
            if (wr_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL rst_mid_write%0d: got addr=%0d d=%b, expected addr=%0d d=%b",
                         i, wr_q[i][10:1], wr_q[i][0], exp_q[i][10:1], exp_q[i][0]);
            end
        end
    endtask

    task automatic test_timeout();
        int s;
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            send_byte(8'(8'h40 + i), s);
            idle(9);
        end
        idle(40);
        n_checks++;
        if (byte_cnt !== 7'd3 || overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL gap_early: got cnt=%0d ovr=%b, expected 3 0", byte_cnt, overrun);
        end
        idle(70);
`ifdef IMG_TIMEOUT_EN
        n_checks++;
        if (byte_cnt !== 7'd0 || overrun !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_resync: got cnt=%0d ovr=%b, expected 0 1", byte_cnt, overrun);
        end
        clear_logs();
        push_exp(0, 8'h81);
`else
        n_checks++;
        if (byte_cnt !== 7'd3 || overrun !== 1'b0) begin
            n_errors++;
            $display("FAIL gap_wait: got cnt=%0d ovr=%b, expected 3 0", byte_cnt, overrun);
        end
        clear_logs();
        push_exp(24, 8'h81);
`endif
        send_byte(8'h81, s);
        idle(12);
        n_checks++;
        if (wr_q.size() != 8) begin
            n_errors++;
            $display("FAIL gap_next_count: got %0d writes, expected 8", wr_q.size());
        end
        for (int i = 0; i < 8 && i < wr_q.size(); i++) begin
            n_checks++;
            if (wr_q[i] !== exp_q[i]) begin
                n_errors++;
                $display("FAIL gap_next_write%0d: got addr=%0d d=%b, expected addr=%0d d=%b",
                         i, wr_q[i][10:1], wr_q[i][0], exp_q[i][10:1], exp_q[i][0]);
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        @(negedge clk);
        test_reset();
        test_single_byte();
        test_full_image();
        test_ready_hold();
        test_back_to_back();
        test_reset_mid_unpack();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
